// File: rtl/rom_port_arbiter_if.sv
// Requester/ROM bundle for the two-port ROM read arbiter.
// master = requesters plus ROM model, slave = arbiter.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;

    modport master (
        output req0, addr0, req1, addr1, rom_q,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, rom_addr
    );

    modport slave (
        input  req0, addr0, req1, addr1, rom_q,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, rom_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of one ROM read port between two requesters,
// with a {valid, port} tag pipeline matching the ROM read latency.
module rom_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    rom_port_arbiter_if.slave      bus
);
    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

    logic              prio;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic [ADDR_W-1:0] addr_mux;
    logic [ADDR_W-1:0] addr_q;

    // Ties go to 'prio'; reset forces both grants low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt0 = bus.req0 & (~bus.req1 | ~prio);
            gnt1 = bus.req1 & (~bus.req0 | prio);
        end
    end

    assign gnt_any = gnt0 | gnt1;

    always_comb begin
        addr_mux = addr_q;
        unique case (1'b1)
            gnt0:    addr_mux = bus.addr0;
            gnt1:    addr_mux = bus.addr1;
            default: addr_mux = addr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio   <= 1'b0;
            addr_q <= '0;
        end else begin
            addr_q <= addr_mux;
            if (gnt_any)
                prio <= ~gnt1;
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rom_addr = addr_mux;
    assign bus.rdata    = bus.rom_q;

    generate
        if (ROM_LAT == 0) begin : g_comb
            assign bus.rvalid0 = gnt0;
            assign bus.rvalid1 = gnt1;
        end else begin : g_pipe
            tag_t tags [ROM_LAT];
            tag_t last;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < ROM_LAT; i++)
                        tags[i] <= '0;
                end else begin
                    tags[0] <= '{valid: gnt_any, port: gnt1};
                    for (int i = 1; i < ROM_LAT; i++)
                        tags[i] <= tags[i-1];
                end
            end

            assign last        = tags[ROM_LAT-1];
            assign bus.rvalid0 = last.valid & ~last.port;
            assign bus.rvalid1 = last.valid & last.port;
        end
    endgenerate
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench: three arbiters with ROM latency 0, 1 and 2,
// each behind a ROM model returning {addr ^ 8'hA5, addr}.
module tb_rom_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rom_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
    rom_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b1 ();
    rom_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b2 ();

    rom_port_arbiter #(.ADDR_W(8), .DATA_W(16), .ROM_LAT(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    rom_port_arbiter #(.ADDR_W(8), .DATA_W(16), .ROM_LAT(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    rom_port_arbiter #(.ADDR_W(8), .DATA_W(16), .ROM_LAT(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2.slave));

    function automatic logic [15:0] f(input logic [7:0] a);
        return {a ^ 8'hA5, a};
    endfunction

    logic [15:0] q2_s1;
    assign b0.rom_q = f(b0.rom_addr);
    always @(posedge clk) b1.rom_q <= f(b1.rom_addr);
    always @(posedge clk) begin
        q2_s1    <= f(b2.rom_addr);
        b2.rom_q <= q2_s1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Settle to mid-cycle, then check grant exclusivity on every DUT.
    task automatic sample();
        #4;
        chk("excl0", 32'(b0.gnt0 & b0.gnt1), 32'd0);
        chk("excl1", 32'(b1.gnt0 & b1.gnt1), 32'd0);
        chk("excl2", 32'(b2.gnt0 & b2.gnt1), 32'd0);
    endtask

    initial begin
        b0.req0 = 0; b0.addr0 = 0; b0.req1 = 0; b0.addr1 = 0;
        b1.req0 = 0; b1.addr0 = 0; b1.req1 = 0; b1.addr1 = 0;
        b2.req0 = 0; b2.addr0 = 0; b2.req1 = 0; b2.addr1 = 0;

        // Reset with both requesting: everything gated off
        nxt();
        b1.req0 = 1; b1.addr0 = 8'h20;
        b1.req1 = 1; b1.addr1 = 8'h30;
        b0.req1 = 1; b0.addr1 = 8'h10;
        sample();
        chk("rst_gnt0", 32'(b1.gnt0), 0);
        chk("rst_gnt1", 32'(b1.gnt1), 0);
        chk("rst_rv0", 32'(b1.rvalid0), 0);
        chk("rst_rv1", 32'(b1.rvalid1), 0);
        chk("rst_l0_gnt1", 32'(b0.gnt1), 0);
        chk("rst_l0_rv1", 32'(b0.rvalid1), 0);
        nxt();
        sample();
        chk("rst2_gnt0", 32'(b1.gnt0), 0);

        // Release; alternating grants starting with port 0
        for (int k = 0; k < 6; k++) begin
            nxt();
            if (k == 0) rst = 0;
            if (k == 1) b0.req1 = 0;
            sample();
            chk("rr_gnt0", 32'(b1.gnt0), 32'(k % 2 == 0));
            chk("rr_gnt1", 32'(b1.gnt1), 32'(k % 2 == 1));
            chk("rr_addr", 32'(b1.rom_addr), (k % 2 == 1) ? 32'h30 : 32'h20);
            if (k == 0) begin
                chk("rr_rv0_first", 32'(b1.rvalid0), 0);
                chk("rr_rv1_first", 32'(b1.rvalid1), 0);
                chk("l0_gnt1", 32'(b0.gnt1), 1);
                chk("l0_rv1", 32'(b0.rvalid1), 1);
                chk("l0_rv0", 32'(b0.rvalid0), 0);
                chk("l0_rdata", 32'(b0.rdata), 32'h00B510);
            end else begin
                chk("rr_rv0", 32'(b1.rvalid0), 32'((k - 1) % 2 == 0));
                chk("rr_rv1", 32'(b1.rvalid1), 32'((k - 1) % 2 == 1));
                chk("rr_rdata", 32'(b1.rdata),
                    ((k - 1) % 2 == 1) ? 32'h9530 : 32'h8520);
            end
        end

        // Idle: last response returns, rom_addr holds
        nxt();
        b1.req0 = 0; b1.req1 = 0;
        sample();
        chk("idle_gnt0", 32'(b1.gnt0), 0);
        chk("idle_gnt1", 32'(b1.gnt1), 0);
        chk("idle_rv1", 32'(b1.rvalid1), 1);
        chk("idle_rdata", 32'(b1.rdata), 32'h9530);
        chk("idle_addr", 32'(b1.rom_addr), 32'h30);
        chk("l0_idle_rv1", 32'(b0.rvalid1), 0);

        // Port 0 streaming 5,6,7
        nxt();
        b1.req0 = 1; b1.addr0 = 8'h05;
        sample();
        chk("s_gnt0_a", 32'(b1.gnt0), 1);
        chk("s_rv0_a", 32'(b1.rvalid0), 0);
        chk("s_rv1_a", 32'(b1.rvalid1), 0);
        nxt();
        b1.addr0 = 8'h06;
        sample();
        chk("s_gnt0_b", 32'(b1.gnt0), 1);
        chk("s_rv0_b", 32'(b1.rvalid0), 1);
        chk("s_rdata_b", 32'(b1.rdata), 32'hA005);
        nxt();
        b1.addr0 = 8'h07;
        sample();
        chk("s_gnt0_c", 32'(b1.gnt0), 1);
        chk("s_rv0_c", 32'(b1.rvalid0), 1);
        chk("s_rdata_c", 32'(b1.rdata), 32'hA306);
        nxt();
        b1.req0 = 0; b1.addr0 = 8'h99;
        sample();
        chk("s_gnt0_d", 32'(b1.gnt0), 0);
        chk("s_rv0_d", 32'(b1.rvalid0), 1);
        chk("s_rdata_d", 32'(b1.rdata), 32'hA207);
        chk("s_addr_hold", 32'(b1.rom_addr), 32'h07);
        nxt();
        sample();
        chk("s_rv0_e", 32'(b1.rvalid0), 0);

        // prio=1 here; lone req1 flips it back to 0
        nxt();
        b1.req1 = 1; b1.addr1 = 8'h11;
        sample();
        chk("p_gnt1_a", 32'(b1.gnt1), 1);
        chk("p_addr_a", 32'(b1.rom_addr), 32'h11);
        nxt();
        b1.req0 = 1; b1.addr0 = 8'h12;
        sample();
        chk("p_gnt0_b", 32'(b1.gnt0), 1);
        chk("p_gnt1_b", 32'(b1.gnt1), 0);
        chk("p_addr_b", 32'(b1.rom_addr), 32'h12);
        chk("p_rv1_b", 32'(b1.rvalid1), 1);
        chk("p_rdata_b", 32'(b1.rdata), 32'hB411);
        nxt();
        sample();
        chk("p_gnt1_c", 32'(b1.gnt1), 1);
        chk("p_gnt0_c", 32'(b1.gnt0), 0);
        chk("p_rv0_c", 32'(b1.rvalid0), 1);
        chk("p_rdata_c", 32'(b1.rdata), 32'hB712);
        nxt();
        b1.req1 = 0;
        sample();
        chk("p_gnt0_d", 32'(b1.gnt0), 1);
        chk("p_rv1_d", 32'(b1.rvalid1), 1);
        chk("p_rdata_d", 32'(b1.rdata), 32'hB411);
        nxt();
        b1.req0 = 0;
        sample();
        chk("p_rv0_e", 32'(b1.rvalid0), 1);
        chk("p_rv1_e", 32'(b1.rvalid1), 0);

        // Latency 2: normal response, then a grant killed by reset
        nxt();
        b2.req0 = 1; b2.addr0 = 8'h41;
        sample();
        chk("l2_gnt0_a", 32'(b2.gnt0), 1);
        nxt();
        b2.req0 = 0;
        sample();
        chk("l2_rv0_t1", 32'(b2.rvalid0), 0);
        nxt();
        sample();
        chk("l2_rv0_t2", 32'(b2.rvalid0), 1);
        chk("l2_rdata", 32'(b2.rdata), 32'hE441);
        nxt();
        sample();
        chk("l2_rv0_t3", 32'(b2.rvalid0), 0);
        nxt();
        b2.req0 = 1; b2.addr0 = 8'h40;
        sample();
        chk("l2_gnt0_b", 32'(b2.gnt0), 1);
        nxt();
        b2.req0 = 0; rst = 1;
        sample();
        chk("l2r_rv0_t1", 32'(b2.rvalid0), 0);
        nxt();
        rst = 0;
        sample();
        chk("l2r_rv0_t2", 32'(b2.rvalid0), 0);
        chk("l2r_rv1_t2", 32'(b2.rvalid1), 0);
        nxt();
        sample();
        chk("l2r_rv0_t3", 32'(b2.rvalid0), 0);

        // Port 0 wins a tie again after reset
        nxt();
        b1.req0 = 1; b1.req1 = 1;
        sample();
        chk("post_rst_gnt0", 32'(b1.gnt0), 1);
        chk("post_rst_gnt1", 32'(b1.gnt1), 0);
        nxt();
        b1.req0 = 0; b1.req1 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
